// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with req/ack memory handshake, one-entry instruction register and redirect handling
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct
);
  typedef enum logic [1:0] {IDLE, REQ, KILL, FULL} state_t;
  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] rpc;
  logic [31:0] kill_pc;
  assign rpc = redirect_pc & 32'hFFFF_FFFC;
  assign kill_pc = redirect ? rpc : target;
  assign opcode = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  // fetch FSM: owns pc, the memory request and the instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      target <= '0;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      instr_valid <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          imem_req <= 1'b1;
          pc <= redirect ? rpc : pc;
          imem_addr <= redirect ? rpc : pc;
        end
        REQ: begin
          if (redirect && imem_ack) begin
            pc <= rpc;
            imem_addr <= rpc;
          end else if (redirect) begin
            target <= rpc;
            state <= KILL;
          end else if (imem_ack) begin
            instr <= imem_rdata;
            instr_pc <= pc;
            instr_valid <= 1'b1;
            pc <= pc + 32'd4;
            imem_req <= 1'b0;
            state <= FULL;
          end
        end
        KILL: begin
          if (imem_ack) begin
            pc <= kill_pc;
            imem_addr <= kill_pc;
            state <= REQ;
          end else if (redirect) begin
            target <= rpc;
          end
        end
        FULL: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc <= rpc;
            imem_addr <= rpc;
            imem_req <= 1'b1;
            state <= REQ;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            imem_addr <= pc;
            imem_req <= 1'b1;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit with a bench-driven instruction memory
module tb_fetch_unit;
  logic        clk, rst_n;
  logic        imem_req, imem_ack, stall, redirect, instr_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 32'h0);
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h012A4020;
    chk("idle_req", 32'(imem_req), 0);
    step();
    chk("c2_req", 32'(imem_req), 1);
    chk("c2_addr", imem_addr, 32'h0);
    chk("c2_valid", 32'(instr_valid), 0);
    step();
    chk("c3_valid", 32'(instr_valid), 1);
    chk("c3_req", 32'(imem_req), 0);
    chk("c3_rd", 32'(rd), 8);
    chk("c3_funct", 32'(funct), 32);
    chk("c3_rs", 32'(rs), 9);
    chk("c3_rt", 32'(rt), 10);
    chk("c3_opcode", 32'(opcode), 0);
    chk("c3_pc", instr_pc, 32'h0);
    imem_ack = 1'b0;
    step();
    chk("c4_req", 32'(imem_req), 1);
    chk("c4_addr", imem_addr, 32'h4);
    chk("c4_valid", 32'(instr_valid), 0);
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    chk("st_cap", instr, 32'h1111_1111);
    imem_ack = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_valid", 32'(instr_valid), 1);
      chk("st_instr", instr, 32'h1111_1111);
      chk("st_pc", instr_pc, 32'h4);
      chk("st_req", 32'(imem_req), 0);
    end
    stall = 1'b0;
    step();
    chk("st_next_req", 32'(imem_req), 1);
    chk("st_next_addr", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("w_req", 32'(imem_req), 1);
      chk("w_addr", imem_addr, 32'h8);
      chk("w_valid", 32'(instr_valid), 0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    step();
    imem_ack = 1'b0;
    chk("w_cap", instr, 32'h2222_2222);
    chk("w_cap_pc", instr_pc, 32'h8);
    chk("w_cap_valid", 32'(instr_valid), 1);
    step();
    chk("r_addr", imem_addr, 32'hC);
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("k_req", 32'(imem_req), 1);
    chk("k_addr", imem_addr, 32'hC);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack = 1'b0;
    chk("k_valid", 32'(instr_valid), 0);
    chk("k_instr", instr, 32'h2222_2222);
    chk("k_addr2", imem_addr, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("k2_addr", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    chk("k2_next", imem_addr, 32'h200);
    chk("k2_valid", 32'(instr_valid), 0);
    imem_rdata = 32'h3333_3333;
    step();
    chk("k2_cap_pc", instr_pc, 32'h200);
    chk("k2_cap_valid", 32'(instr_valid), 1);
    imem_ack = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("f_valid", 32'(instr_valid), 0);
    chk("f_req", 32'(imem_req), 1);
    chk("f_addr", imem_addr, 32'h100);
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_rdata = 32'hDEADBEEF;
    step();
    redirect = 1'b0;
    chk("ar_addr", imem_addr, 32'hFFFF_FFFC);
    chk("ar_valid", 32'(instr_valid), 0);
    imem_rdata = 32'h4444_4444;
    step();
    imem_ack = 1'b0;
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr, 32'h4444_4444);
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(imem_req), 0);
    chk("ar_rvalid", 32'(instr_valid), 0);
    chk("ar_instr", instr, 32'h0);
    chk("ar_ipc", instr_pc, 32'h0);
    chk("ar_addr0", imem_addr, 32'h0);
    step();
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    chk("post_req", 32'(imem_req), 1);
    chk("post_valid", 32'(instr_valid), 0);
    chk("post_instr", instr, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the decode logic (control unit and register-file read ports). It owns the fetch program counter, runs a req/ack handshake with instruction memory, and holds one fetched instruction in an instruction register. It presents the instruction, its PC and pre-sliced decode fields to the consumer, and honours stall and branch-redirect requests from downstream.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- imem_req  out  1  instruction memory request; driven from a register.
- imem_addr  out  32  fetch address, always word-aligned; driven from a register.
- imem_ack  in  1  memory response; imem_rdata is valid in the cycle imem_ack=1.
- imem_rdata  in  32  instruction word.
- stall  in  1  consumer not ready; the held instruction must not be consumed.
- redirect  in  1  one-cycle pulse: discard in-flight and held work, continue fetching at redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored and stored as 0.
- instr_valid  out  1  instr and instr_pc hold a valid instruction.
- instr  out  32  held instruction word.
- instr_pc  out  32  address the instruction was fetched from.
- opcode/rs/rt/rd/shamt/funct  out  6/5/5/5/5/6  combinational slices of instr: [31:26], [25:21], [20:16], [15:11], [10:6], [5:0].

## Operation
- States: IDLE, REQ, KILL, FULL. Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0 (all decode fields 0), instr_pc=0, saved target=0.
- IDLE: leave on the first posedge after reset release and go to REQ. redirect in IDLE loads pc before entering REQ.
- REQ: imem_req=1, imem_addr=pc. The address must stay stable until an edge where imem_ack=1.
  - ack, no redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to FULL.
  - ack and redirect: discard the data, pc<=redirect_pc, stay in REQ. The new address is driven next cycle.
  - redirect, no ack: save redirect_pc as the target, go to KILL. The request cannot be withdrawn.
- KILL: imem_req=1, imem_addr holds the old pc. A further redirect overwrites the saved target (latest wins). On ack: discard the data, pc<=saved target (or redirect_pc if redirect is high in the same cycle), go to REQ.
- FULL: imem_req=0, instr_valid=1.
  - redirect: instr_valid<=0, pc<=redirect_pc, go to REQ. Redirect has priority over both consume and stall.
  - stall=0: instruction consumed; instr_valid<=0, go to REQ.
  - stall=1: hold everything, for any number of cycles.
- imem_ack outside REQ/KILL is ignored. stall is ignored when instr_valid=0.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Asserting reset mid-handshake returns all state to reset values immediately. The outstanding memory response is not awaited; any ack after reset release while in IDLE is ignored.

## Timing
- First imem_req=1 appears in the second cycle after reset release (the IDLE cycle comes first).
- Zero-wait memory (ack in the request cycle): instr_valid rises one cycle after req. Peak throughput is one instruction per 2 cycles.
- N wait cycles add N cycles of latency. instr_valid is never high while imem_req is high.
- Redirect to the first request of the new target: 1 cycle from FULL or REQ+ack; ack cycle + 1 from KILL.
- Decode fields change only on edges where instr is loaded.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning word 32'h012A4020 at address 0 -> imem_req=1 with addr 0 in cycle 2; instr_valid=1, rd=8, funct=32, instr_pc=0 in cycle 3; next request addr=4 in cycle 4.
- stall held high for 5 cycles while FULL -> instr, instr_pc and instr_valid remain constant and imem_req=0; after stall drops, the next request goes to pc+4.
- Memory with 3 wait cycles -> imem_addr stable over the 4 request cycles; exactly one capture.
- redirect to 32'h0000_0100 during a wait cycle, then ack with data 32'hDEADBEEF -> data discarded, instr_valid stays 0, next imem_addr=32'h100. A second redirect to 32'h200 before the ack -> next imem_addr=32'h200.
- redirect_pc=32'h0000_0103 in FULL with stall=1 -> instr_valid=0 next cycle, imem_addr=32'h100.
- pc=32'hFFFF_FFFC fetch -> next imem_addr=0. Reset asserted mid-wait -> outputs return to reset values asynchronously.
